tiger_muldiv_ctrl: RTL and testbench
====================================

// Module: tiger_muldiv_ctrl
// PURPOSE
//   Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Owns the HI/LO registers and
//   runs radix-2^RB shift-add / shift-subtract iterations over latched operands.
//   Sits beside the single-cycle ALU in the execute stage.
//   Drives stall to hold the pipeline while an operation is in flight or HI/LO is read early.
// PARAMETERS
//   RB     1   result bits retired per CALC cycle; legal values 1 or 2
//   DW     32  operand width; fixed at 32, present for documentation only
// PORTS
//   clk        in   1   rising-edge clock
//   reset_n    in   1   synchronous reset, active low
//   start      in   1   launch operation; sampled only in IDLE
//   op         in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srca       in   32  rs: multiplicand / dividend
//   srcb       in   32  rt: multiplier / divisor
//   mthi       in   1   write HI <- srca (MTHI)
//   mtlo       in   1   write LO <- srca (MTLO)
//   hilo_rd    in   1   execute stage wants HI or LO (MFHI/MFLO)
//   hi         out  32  HI register
//   lo         out  32  LO register
//   busy       out  1   state != IDLE
//   stall      out  1   busy & (start | hilo_rd | mthi | mtlo)
//   done       out  1   one-cycle pulse when HI/LO are updated by an operation
// BEHAVIOUR
//   Reset (reset_n=0 at an edge): state=IDLE, hi=lo=0, done=0, busy=0, all internal regs 0.
//     Applies mid-operation: the operation is discarded and HI/LO are cleared.
//   FSM: IDLE -start-> PREP -> CALC (32/RB cycles) -> FIX -> IDLE.
//   IDLE: on start, latch op/srca/srcb; go to PREP. An unrecognised op cannot occur (2 bits).
//   PREP: signed ops take abs values and record result signs;
//     DIV: quotient sign = a[31]^b[31], remainder sign = a[31]. MULT: product sign = a[31]^b[31].
//     Unsigned ops pass operands through unchanged.
//   CALC: MUL = 64-bit shift-add, RB multiplier bits per cycle;
//     DIV = restoring shift-subtract, RB quotient bits per cycle; counter down from 32/RB-1.
//   FIX: negate product/quotient/remainder per the signs from PREP.
//     Write hi <- product[63:32] or remainder; lo <- product[31:0] or quotient.
//     Assert done in the cycle after this edge.
//   Latency: start sampled at edge E -> busy=1 after E; HI/LO valid and done=1 after
//     edge E+2+32/RB (34 cycles for RB=1, 18 for RB=2); busy=0 in that same cycle.
//   Divide by zero (srcb=0): no trap; runs full latency.
//     DIVU: lo=32'hFFFF_FFFF, hi=srca.
//     DIV: lo = srca[31] ? 32'h0000_0001 : 32'hFFFF_FFFF, hi=srca.
//   Signed overflow DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
//   start, mthi, mtlo while busy: ignored by this block; stall=1 so the pipeline re-presents them.
//   mthi/mtlo in IDLE: take effect at the edge. If start is asserted the same cycle,
//     the write happens and the operation's result later overwrites HI/LO.
//   mthi and mtlo together: both written from srca.
//   hilo_rd in IDLE: no stall, hi/lo are combinationally current register values.
//   done never asserts for mthi/mtlo writes.
// TESTING
//   1. MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> after 34 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001, done pulses once.
//   2. MULT a=-3, b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
//      DIV a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
//   3. DIVU a=100, b=0 -> lo=32'hFFFF_FFFF, hi=100.
//      DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
//   4. hilo_rd=1 held from cycle 5 of a DIVU -> stall=1 until busy falls.
//      start pulse at cycle 10 is ignored (result still that of the first op).
//   5. reset_n=0 for one edge at CALC cycle 12 -> next cycle state IDLE, hi=lo=0, busy=0, no done pulse.
//   6. RB=2 build, repeat 1-3 -> identical results, done exactly 18 cycles after start.
//      mthi+start together in IDLE -> hi=srca briefly, then overwritten at done.

Source files
------------

// File: rtl/tiger_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; retires RB result bits
// per CALC cycle using shift-add multiply and restoring shift-subtract divide.
module tiger_muldiv_ctrl #(
    parameter int RB = 1,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] srca,
    input  logic [DW-1:0] srcb,
    input  logic          mthi,
    input  logic          mtlo,
    input  logic          hilo_rd,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          busy,
    output logic          stall,
    output logic          done
);

    localparam int NCYC = 32 / RB;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t      state_reg;
    logic [1:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] acc_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    logic        is_div;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] prod_fix;

    assign is_div    = op_reg[1];
    assign is_signed = ~op_reg[0];
    assign abs_a     = (is_signed && a_reg[31]) ? -a_reg : a_reg;
    assign abs_b     = (is_signed && b_reg[31]) ? -b_reg : b_reg;
    assign quo_fix   = neg_q_reg ? -acc_reg[31:0]  : acc_reg[31:0];
    assign rem_fix   = neg_r_reg ? -acc_reg[63:32] : acc_reg[63:32];
    assign prod_fix  = neg_q_reg ? -acc_reg : acc_reg;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    logic [63:0] stage [0:RB];
    assign stage[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < RB; gi++) begin : g_step
            logic [32:0] mul_sum;
            logic [64:0] div_sh;
            logic [32:0] div_trial;

            assign mul_sum   = {1'b0, stage[gi][63:32]} + (stage[gi][0] ? {1'b0, a_reg} : 33'd0);
            assign div_sh    = {stage[gi], 1'b0};
            assign div_trial = div_sh[64:32] - {1'b0, b_reg};
            assign stage[gi+1] = is_div
                ? (div_trial[32] ? div_sh[63:0] : {div_trial[31:0], div_sh[31:1], 1'b1})
                : {mul_sum, stage[gi][31:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            op_reg    <= 2'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            acc_reg   <= 64'd0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            cnt_reg   <= 5'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mthi) hi_reg <= srca;
                    if (mtlo) lo_reg <= srca;
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= srca;
                        b_reg     <= srcb;
                        state_reg <= PREP;
                    end
                end
                PREP: begin
                    a_reg     <= abs_a;
                    b_reg     <= abs_b;
                    acc_reg   <= {32'd0, (is_div ? abs_a : abs_b)};
                    neg_q_reg <= is_signed & (a_reg[31] ^ b_reg[31]);
                    neg_r_reg <= is_signed & a_reg[31];
                    cnt_reg   <= 5'(NCYC - 1);
                    state_reg <= CALC;
                end
                CALC: begin
                    acc_reg <= stage[RB];
                    cnt_reg <= cnt_reg - 5'd1;
                    if (cnt_reg == 5'd0) state_reg <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign done  = done_reg;
    assign busy  = (state_reg != IDLE);
    assign stall = busy & (start | hilo_rd | mthi | mtlo);

endmodule

// File: tb/tb_tiger_muldiv_ctrl.sv
// Directed bench for tiger_muldiv_ctrl: RB=1 and RB=2 instances share stimulus,
// expected HI/LO are queued at launch and popped once the operation completes.
module tb_tiger_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, start, mthi, mtlo, hilo_rd;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic [31:0] hi1, lo1, hi2, lo2;
    logic        busy1, stall1, done1, busy2, stall2, done2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb[$];

    always #5 clk = ~clk;

    tiger_muldiv_ctrl #(.RB(1), .DW(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mthi(mthi), .mtlo(mtlo), .hilo_rd(hilo_rd), .hi(hi1), .lo(lo1),
        .busy(busy1), .stall(stall1), .done(done1)
    );

    tiger_muldiv_ctrl #(.RB(2), .DW(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mthi(mthi), .mtlo(mtlo), .hilo_rd(hilo_rd), .hi(hi2), .lo(lo2),
        .busy(busy2), .stall(stall2), .done(done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic signed [63:0] p;
        logic [63:0] u;
        r = '0;
        case (o)
            2'b00: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b01: begin
                u = {32'd0, a} * {32'd0, b};
                r.hi = u[63:32];
                r.lo = u[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    r.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    r.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000;
                    r.hi = 32'd0;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = a;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input res_t exp, input int rd_from,
                          input int start_at, input int rst_at, input bit do_mthi);
        int at1, at2, nd1, nd2, exp_nd;
        res_t want;
        at1 = -1; at2 = -1; nd1 = 0; nd2 = 0;
        exp_nd = (rst_at < 0) ? 1 : 0;
        sb.push_back(exp);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1; mthi = do_mthi;
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            if (done1) begin nd1++; at1 = c; end
            if (done2) begin nd2++; at2 = c; end
            if (c == 0) begin
                chk({name, "_busy1"}, busy1, 1'b1);
                chk({name, "_busy2"}, busy2, 1'b1);
                if (do_mthi) begin
                    chk({name, "_mthi_hi1"}, hi1, a);
                    chk({name, "_mthi_hi2"}, hi2, a);
                end
                start = 1'b0; mthi = 1'b0;
                srca = $urandom; srcb = $urandom;
            end
            if (rst_at < 0 && c == 34) chk({name, "_idle1"}, busy1, 1'b0);
            if (rst_at < 0 && c == 18) chk({name, "_idle2"}, busy2, 1'b0);
            if (c == rst_at) reset_n = 1'b0;
            if (rst_at >= 0 && c == rst_at + 1) begin
                reset_n = 1'b1;
                chk({name, "_rst_busy1"}, busy1, 1'b0);
                chk({name, "_rst_busy2"}, busy2, 1'b0);
                chk({name, "_rst_hilo1"}, {hi1, lo1}, 64'd0);
                chk({name, "_rst_hilo2"}, {hi2, lo2}, 64'd0);
            end
            if (c == rd_from) hilo_rd = 1'b1;
            if (c == start_at) begin
                start = 1'b1; op = ~o; srca = 32'h5555_5555; srcb = 32'd3;
            end
            if (c == start_at + 1) start = 1'b0;
            #1;
            if (hilo_rd) begin
                chk({name, "_stall1"}, stall1, (c < 34));
                chk({name, "_stall2"}, stall2, (c < 18));
            end
        end
        hilo_rd = 1'b0;
        chk({name, "_ndone1"}, nd1, exp_nd);
        chk({name, "_ndone2"}, nd2, exp_nd);
        if (rst_at < 0) begin
            chk({name, "_lat1"}, at1, 34);
            chk({name, "_lat2"}, at2, 18);
        end
        want = sb.pop_front();
        chk({name, "_hilo1"}, {hi1, lo1}, want);
        chk({name, "_hilo2"}, {hi2, lo2}, want);
        $display("%s op=%0d a=%h b=%h rb1 hi=%h lo=%h rb2 hi=%h lo=%h", name, o, a, b, hi1, lo1, hi2, lo2);
    endtask

    initial begin
        res_t r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
        op = 2'd0; srca = 32'd0; srcb = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset_hilo1", {hi1, lo1}, 64'd0);
        chk("reset_hilo2", {hi2, lo2}, 64'd0);
        chk("reset_ctl1", {busy1, done1}, 2'b00);
        chk("reset_ctl2", {busy2, done2}, 2'b00);
        reset_n = 1'b1;

        // Idle read never stalls; MTHI+MTLO together write both from srca with no done.
        @(negedge clk);
        hilo_rd = 1'b1; mthi = 1'b1; mtlo = 1'b1; srca = 32'h1234_5678;
        #1;
        chk("idle_rd_stall1", stall1, 1'b0);
        chk("idle_rd_stall2", stall2, 1'b0);
        @(negedge clk);
        hilo_rd = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_1", {hi1, lo1}, {32'h1234_5678, 32'h1234_5678});
        chk("mthilo_2", {hi2, lo2}, {32'h1234_5678, 32'h1234_5678});
        chk("mthilo_done", {done1, done2}, 2'b00);
        $display("mthi_mtlo srca=%h hi=%h lo=%h", 32'h1234_5678, hi1, lo1);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, -1, -1, -1, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, -1, -1, -1, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, -1, -1, 1'b0);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, -1, -1, -1, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1, -1, -1, 1'b0);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'h0000_0001}, -1, -1, -1, 1'b0);
        run_op("divu_rd_start", 2'b11, 32'd1000, 32'd7, {32'd6, 32'd142}, 5, 10, -1, 1'b0);
        run_op("multu_reset", 2'b01, 32'd12345, 32'd678, {32'd0, 32'd0}, -1, -1, 12, 1'b0);
        run_op("mthi_start", 2'b00, 32'hCAFE_0001, 32'd2, {32'hFFFF_FFFF, 32'h95FC_0002}, -1, -1, -1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            ro = 2'(i);
            ra = $urandom;
            rb = $urandom | 32'd1;
            r  = model(ro, ra, rb);
            run_op("random", ro, ra, rb, r, -1, -1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
